// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg
// Shared types for the parametrised data stack.
//   op_t       : operation codes on the op port (3'd6/3'd7 decode as NOP)
//   cell_sel_t : per-entry next-value select used between top and stack_cell
//   size_w()   : bit width needed to count 0..depth entries inclusive
// ---------------------------------------------------------------------------
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_SWAP    = 3'd4,
    OP_DUP     = 3'd5
  } op_t;

  typedef enum logic [2:0] {
    SEL_HOLD      = 3'd0,
    SEL_LOAD_DIN  = 3'd1,
    SEL_TAKE_PREV = 3'd2,  // value of the entry above (shift down)
    SEL_TAKE_NEXT = 3'd3,  // value of the entry below (shift up)
    SEL_ZERO      = 3'd4
  } cell_sel_t;

  function automatic int size_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_cell.sv
// ---------------------------------------------------------------------------
// stack_cell
// One stack entry register. The top decides what every cell does each cycle;
// the cell only muxes its next value.
//   clk, async_reset : clock, asynchronous active-high reset
//   sel              : hold / load din / take prev / take next / zero
//   din              : external data word
//   prev_q           : current value of the entry above (index-1)
//   next_q           : current value of the entry below (index+1)
//   q                : registered entry value
// ---------------------------------------------------------------------------
module stack_cell
  import stack_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             async_reset,
  input  cell_sel_t        sel,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] prev_q,
  input  logic [WIDTH-1:0] next_q,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    // NOTE: assign a default first so every path drives q_d; otherwise a latch is inferred.
    q_d = q_q;
    case (sel)
      SEL_LOAD_DIN:  q_d = din;
      SEL_TAKE_PREV: q_d = prev_q;
      SEL_TAKE_NEXT: q_d = next_q;
      SEL_ZERO:      q_d = '0;
      default:       q_d = q_q;
    endcase
  end

  // NOTE: entries are reset (not left as uninitialised storage) because unused
  // entries must read 0 from the very first cycle.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      q_q <= '0;
    end else begin
      // NOTE: non-blocking so all cells sample their neighbours' old values in the same edge.
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/param_data_stack.sv
// ---------------------------------------------------------------------------
// param_data_stack
// WIDTH x DEPTH LIFO with registered TOS/NOS, encoded op port, exact size,
// sticky overflow/underflow flags and optional bottom spill on full push.
//   clk, async_reset : clock, asynchronous active-high reset
//   op               : op_t code, one op per cycle
//   din              : data for PUSH / REPLACE
//   clear_flags      : clears sticky flags (a same-cycle set wins)
//   tos, nos         : entry 0 / entry 1 (0 when not valid)
//   size             : number of valid entries, 0..DEPTH
//   empty, full      : decoded from registered size
//   overflow         : sticky, push rejected on full (SPILL_EN=0)
//   underflow        : sticky, op needed more entries than present
//   spill_valid      : one-cycle pulse, bottom entry ejected on full push
//   spill_data       : ejected entry, 0 when spill_valid is low
// ---------------------------------------------------------------------------
module param_data_stack
  import stack_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 128,
  parameter  int SPILL_EN = 0,
  localparam int SIZE_W   = size_w(DEPTH)
) (
  input  logic              clk,
  input  logic              async_reset,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  din,
  input  logic              clear_flags,
  output logic [WIDTH-1:0]  tos,
  output logic [WIDTH-1:0]  nos,
  output logic [SIZE_W-1:0] size,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              spill_valid,
  output logic [WIDTH-1:0]  spill_data
);

  logic [WIDTH-1:0]  entry_q [DEPTH];
  cell_sel_t         sel     [DEPTH];

  logic [SIZE_W-1:0] size_d, size_q;
  logic              overflow_d, overflow_q;
  logic              underflow_d, underflow_q;
  logic              spill_valid_d, spill_valid_q;
  logic [WIDTH-1:0]  spill_data_d, spill_data_q;

  logic is_empty, is_full;
  logic push_req, load_top;
  logic under_fault, over_fault;
  logic do_push, do_pop, do_swap, do_replace, do_spill;

  assign is_empty = (size_q == '0);
  assign is_full  = (size_q == SIZE_W'(DEPTH));

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    logic [WIDTH-1:0] prev_w, next_w;

    if (gi == 0) begin : g_first
      assign prev_w = '0;
    end else begin : g_prev
      assign prev_w = entry_q[gi-1];
    end

    if (gi == DEPTH - 1) begin : g_last
      assign next_w = '0;
    end else begin : g_next
      assign next_w = entry_q[gi+1];
    end

    stack_cell #(.WIDTH(WIDTH)) u_cell (
      .clk         (clk),
      .async_reset (async_reset),
      .sel         (sel[gi]),
      .din         (din),
      .prev_q      (prev_w),
      .next_q      (next_w),
      .q           (entry_q[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Op decode, faults, next size/flags/spill and per-cell selects
  // ---------------------------------------------------------------------------
  always_comb begin
    push_req   = 1'b0;
    load_top   = 1'b0;
    do_pop     = 1'b0;
    do_swap    = 1'b0;
    do_replace = 1'b0;
    under_fault = 1'b0;

    case (op)
      OP_PUSH: begin
        push_req = 1'b1;
        load_top = 1'b1;
      end
      OP_DUP: begin
        // DUP pushes a copy of entry 0: entry 0 holds, the rest shift down.
        push_req    = !is_empty;
        under_fault = is_empty;
      end
      OP_POP: begin
        do_pop      = !is_empty;
        under_fault = is_empty;
      end
      OP_REPLACE: begin
        // REPLACE on an empty stack acts as PUSH.
        push_req   = is_empty;
        load_top   = is_empty;
        do_replace = !is_empty;
      end
      OP_SWAP: begin
        do_swap     = (size_q >= SIZE_W'(2));
        under_fault = (size_q <  SIZE_W'(2));
      end
      default: ;
    endcase

    over_fault = push_req && is_full && (SPILL_EN == 0);
    do_push    = push_req && !over_fault;
    // A full-stack push that was not rejected ejects the bottom entry.
    do_spill   = do_push && is_full;

    size_d = size_q;
    if (do_push && !is_full) begin
      size_d = size_q + SIZE_W'(1);
    end else if (do_pop) begin
      size_d = size_q - SIZE_W'(1);
    end

    overflow_d  = over_fault  ? 1'b1 : (clear_flags ? 1'b0 : overflow_q);
    underflow_d = under_fault ? 1'b1 : (clear_flags ? 1'b0 : underflow_q);

    spill_valid_d = do_spill;
    spill_data_d  = do_spill ? entry_q[DEPTH-1] : '0;

    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = SEL_HOLD;
      if (do_push) begin
        if (i == 0) begin
          sel[i] = load_top ? SEL_LOAD_DIN : SEL_HOLD;
        end else begin
          sel[i] = SEL_TAKE_PREV;
        end
      end else if (do_pop) begin
        sel[i] = (i == DEPTH - 1) ? SEL_ZERO : SEL_TAKE_NEXT;
      end else if (do_replace) begin
        if (i == 0) sel[i] = SEL_LOAD_DIN;
      end else if (do_swap) begin
        if (i == 0) sel[i] = SEL_TAKE_NEXT;
        if (i == 1) sel[i] = SEL_TAKE_PREV;
      end
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      size_q        <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      spill_valid_q <= 1'b0;
      spill_data_q  <= '0;
    end else begin
      size_q        <= size_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      spill_valid_q <= spill_valid_d;
      spill_data_q  <= spill_data_d;
    end
  end

  assign tos         = entry_q[0];
  assign nos         = entry_q[1];
  assign size        = size_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign spill_valid = spill_valid_q;
  assign spill_data  = spill_data_q;

endmodule

// File: tb/tb_param_data_stack.sv
// ---------------------------------------------------------------------------
// tb_param_data_stack
// Two DEPTH=4 instances (SPILL_EN=0 and SPILL_EN=1) share one stimulus stream.
// A queue-based model per instance predicts every output; a compare process
// checks both instances on each falling edge, and directed sequences add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_param_data_stack;
  import stack_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int SW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             async_reset;
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic             clear_flags;

  logic [WIDTH-1:0] tos_o   [2];
  logic [WIDTH-1:0] nos_o   [2];
  logic [SW-1:0]    size_o  [2];
  logic             empty_o [2];
  logic             full_o  [2];
  logic             ovf_o   [2];
  logic             unf_o   [2];
  logic             sv_o    [2];
  logic [WIDTH-1:0] sd_o    [2];

  always #5 clk = ~clk;

  param_data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SPILL_EN(0)) u_dut0 (
    .clk(clk), .async_reset(async_reset), .op(op), .din(din), .clear_flags(clear_flags),
    .tos(tos_o[0]), .nos(nos_o[0]), .size(size_o[0]), .empty(empty_o[0]), .full(full_o[0]),
    .overflow(ovf_o[0]), .underflow(unf_o[0]), .spill_valid(sv_o[0]), .spill_data(sd_o[0])
  );

  param_data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SPILL_EN(1)) u_dut1 (
    .clk(clk), .async_reset(async_reset), .op(op), .din(din), .clear_flags(clear_flags),
    .tos(tos_o[1]), .nos(nos_o[1]), .size(size_o[1]), .empty(empty_o[1]), .full(full_o[1]),
    .overflow(ovf_o[1]), .underflow(unf_o[1]), .spill_valid(sv_o[1]), .spill_data(sd_o[1])
  );

  // ---------------------------------------------------------------------------
  // Reference model: front of the queue is the top of stack
  // ---------------------------------------------------------------------------
  typedef logic [WIDTH-1:0] word_q_t [$];

  word_q_t          m_stk [2];
  logic             m_ovf [2];
  logic             m_unf [2];
  logic             m_sv  [2];
  logic [WIDTH-1:0] m_sd  [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_stk[k].delete();
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
      m_sv[k]  = 1'b0;
      m_sd[k]  = '0;
    end
  endtask

  task automatic model_step(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic clr);
    for (int k = 0; k < 2; k++) begin
      word_q_t          s;
      int               n;
      logic             set_ov, set_un;
      logic [WIDTH-1:0] w;
      s      = m_stk[k];
      n      = s.size();
      set_ov = 1'b0;
      set_un = 1'b0;
      m_sv[k] = 1'b0;
      m_sd[k] = '0;
      case (o)
        3'd1, 3'd5: begin
          if (o == 3'd5 && n == 0) begin
            set_un = 1'b1;
          end else begin
            w = (o == 3'd1) ? d : s[0];
            if (n < DEPTH) begin
              s.push_front(w);
            end else if (k == 1) begin
              m_sd[k] = s.pop_back();
              m_sv[k] = 1'b1;
              s.push_front(w);
            end else begin
              set_ov = 1'b1;
            end
          end
        end
        3'd2: begin
          if (n > 0) void'(s.pop_front());
          else       set_un = 1'b1;
        end
        3'd3: begin
          if (n == 0) s.push_front(d);
          else        s[0] = d;
        end
        3'd4: begin
          if (n >= 2) begin
            w    = s[0];
            s[0] = s[1];
            s[1] = w;
          end else begin
            set_un = 1'b1;
          end
        end
        default: ;
      endcase
      m_stk[k] = s;
      m_ovf[k] = set_ov ? 1'b1 : (clr ? 1'b0 : m_ovf[k]);
      m_unf[k] = set_un ? 1'b1 : (clr ? 1'b0 : m_unf[k]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle comparison of both instances against the model
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (async_reset === 1'b0) begin
      for (int k = 0; k < 2; k++) begin
        int               n;
        logic [WIDTH-1:0] e_tos, e_nos;
        n     = m_stk[k].size();
        e_tos = (n >= 1) ? m_stk[k][0] : '0;
        e_nos = (n >= 2) ? m_stk[k][1] : '0;
        check($sformatf("dut%0d.tos", k),         32'(tos_o[k]),   32'(e_tos));
        check($sformatf("dut%0d.nos", k),         32'(nos_o[k]),   32'(e_nos));
        check($sformatf("dut%0d.size", k),        32'(size_o[k]),  32'(n));
        check($sformatf("dut%0d.empty", k),       32'(empty_o[k]), 32'(n == 0));
        check($sformatf("dut%0d.full", k),        32'(full_o[k]),  32'(n == DEPTH));
        check($sformatf("dut%0d.overflow", k),    32'(ovf_o[k]),   32'(m_ovf[k]));
        check($sformatf("dut%0d.underflow", k),   32'(unf_o[k]),   32'(m_unf[k]));
        check($sformatf("dut%0d.spill_valid", k), 32'(sv_o[k]),    32'(m_sv[k]));
        check($sformatf("dut%0d.spill_data", k),  32'(sd_o[k]),    32'(m_sd[k]));
      end
    end
  end

  // Drive one op at a falling edge, let it be sampled, return at the next falling edge.
  task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic c);
    op          = o;
    din         = d;
    clear_flags = c;
    @(posedge clk);
    model_step(o, d, c);
    @(negedge clk);
    op          = 3'd0;
    din         = '0;
    clear_flags = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.dut%0d.tos", tag, k),   32'(tos_o[k]),   32'd0);
      check($sformatf("%s.dut%0d.nos", tag, k),   32'(nos_o[k]),   32'd0);
      check($sformatf("%s.dut%0d.size", tag, k),  32'(size_o[k]),  32'd0);
      check($sformatf("%s.dut%0d.empty", tag, k), 32'(empty_o[k]), 32'd1);
      check($sformatf("%s.dut%0d.full", tag, k),  32'(full_o[k]),  32'd0);
      check($sformatf("%s.dut%0d.flags", tag, k), 32'({ovf_o[k], unf_o[k]}), 32'd0);
      check($sformatf("%s.dut%0d.spill", tag, k), 32'({sv_o[k], sd_o[k]}),   32'd0);
    end
  endtask

  initial begin
    async_reset = 1'b1;
    op          = 3'd0;
    din         = '0;
    clear_flags = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    async_reset = 1'b0;

    // Basic push/pop
    do_op(3'd1, 16'h1111, 1'b0);
    do_op(3'd1, 16'h2222, 1'b0);
    do_op(3'd1, 16'h3333, 1'b0);
    check("lit.push3.tos",  32'(tos_o[0]),  32'h3333);
    check("lit.push3.nos",  32'(nos_o[0]),  32'h2222);
    check("lit.push3.size", 32'(size_o[0]), 32'd3);
    for (int i = 0; i < 3; i++) do_op(3'd2, '0, 1'b0);
    check("lit.pop3.tos",   32'(tos_o[0]),   32'd0);
    check("lit.pop3.empty", 32'(empty_o[0]), 32'd1);
    check("lit.pop3.flags", 32'({ovf_o[0], unf_o[0]}), 32'd0);

    // Underflow and flag clearing priority
    do_op(3'd2, '0, 1'b0);
    check("lit.pop_empty.size", 32'(size_o[0]), 32'd0);
    check("lit.pop_empty.unf",  32'(unf_o[0]),  32'd1);
    do_op(3'd0, '0, 1'b1);
    check("lit.clear.unf", 32'(unf_o[0]), 32'd0);
    do_op(3'd2, '0, 1'b1);
    check("lit.set_wins.unf", 32'(unf_o[1]), 32'd1);
    do_op(3'd0, '0, 1'b1);

    // Full-stack push: fault on dut0, spill on dut1
    for (int i = 1; i <= 4; i++) do_op(3'd1, 16'(i), 1'b0);
    do_op(3'd1, 16'd5, 1'b0);
    check("lit.ovf.size", 32'(size_o[0]), 32'd4);
    check("lit.ovf.tos",  32'(tos_o[0]),  32'd4);
    check("lit.ovf.flag", 32'(ovf_o[0]),  32'd1);
    check("lit.ovf.sv",   32'(sv_o[0]),   32'd0);
    check("lit.spill.tos",  32'(tos_o[1]),  32'd5);
    check("lit.spill.size", 32'(size_o[1]), 32'd4);
    check("lit.spill.sv",   32'(sv_o[1]),   32'd1);
    check("lit.spill.sd",   32'(sd_o[1]),   32'd1);
    check("lit.spill.ovf",  32'(ovf_o[1]),  32'd0);
    do_op(3'd2, '0, 1'b0);
    check("lit.spill.pulse_end", 32'(sv_o[1]), 32'd0);
    check("lit.spill.pop1", 32'(tos_o[1]), 32'd4);
    do_op(3'd2, '0, 1'b0);
    check("lit.spill.pop2", 32'(tos_o[1]), 32'd3);
    do_op(3'd2, '0, 1'b0);
    check("lit.spill.pop3", 32'(tos_o[1]), 32'd2);
    do_op(3'd2, '0, 1'b1);
    check("lit.spill.pop4", 32'(tos_o[1]), 32'd0);

    // SWAP / DUP / REPLACE on stack {tos=0xA, nos=0xB}
    do_op(3'd1, 16'h000B, 1'b0);
    do_op(3'd1, 16'h000A, 1'b0);
    do_op(3'd4, '0, 1'b0);
    check("lit.swap.tos", 32'(tos_o[0]), 32'hB);
    check("lit.swap.nos", 32'(nos_o[0]), 32'hA);
    do_op(3'd5, '0, 1'b0);
    check("lit.dup.tos",  32'(tos_o[0]),  32'hB);
    check("lit.dup.size", 32'(size_o[0]), 32'd3);
    do_op(3'd3, 16'h000C, 1'b0);
    check("lit.repl.tos",  32'(tos_o[0]),  32'hC);
    check("lit.repl.size", 32'(size_o[0]), 32'd3);
    do_op(3'd2, '0, 1'b0);
    do_op(3'd2, '0, 1'b0);
    do_op(3'd4, '0, 1'b0);
    check("lit.swap1.unf", 32'(unf_o[0]), 32'd1);
    check("lit.swap1.tos", 32'(tos_o[0]), 32'hA);

    // Asynchronous reset between edges with size 3
    do_op(3'd1, 16'h0077, 1'b0);
    do_op(3'd1, 16'h0088, 1'b0);
    check("lit.pre_rst.size", 32'(size_o[0]), 32'd3);
    op  = 3'd1;
    din = 16'hDEAD;
    #2;
    async_reset = 1'b1;
    model_reset();
    #1;
    check_all_zero("async");
    @(posedge clk);
    @(negedge clk);
    async_reset = 1'b0;
    op  = 3'd0;
    din = '0;
    @(negedge clk);
    check("lit.post_rst.empty", 32'(empty_o[0]), 32'd1);
    do_op(3'd1, 16'h0055, 1'b0);
    do_op(3'd6, 16'h1234, 1'b0);
    do_op(3'd7, 16'h5678, 1'b0);
    check("lit.op67.tos",  32'(tos_o[0]),  32'h55);
    check("lit.op67.size", 32'(size_o[1]), 32'd1);

    // Randomised traffic, push-biased so both full and empty are visited
    for (int i = 0; i < 600; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) o = 3'd1;
      do_op(o, 16'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_data_stack.md
# param_data_stack

Parametrised successor to the fixed 128×16 register stack: a WIDTH×DEPTH LIFO with registered top-of-stack (TOS) and next-on-stack (NOS) outputs, an encoded operation port (push, pop, replace, swap, dup), exact occupancy count, sticky overflow/underflow flags and an optional bottom-spill port toward memory. It sits between the control unit, which issues one op per cycle, and the data processor, which consumes TOS/NOS.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 128, number of stack entries (≥2)
- SPILL_EN, 0, 1 = push on full spills the bottom entry instead of faulting
- clk  in  1  single clock, all state on rising edge
- async_reset  in  1  asynchronous, active-high reset
- op  in  3  operation code (stack_pkg op_t), sampled every edge
- din  in  WIDTH  data for PUSH/REPLACE
- clear_flags  in  1  clears sticky overflow/underflow
- tos  out  WIDTH  entry 0 (top); 0 when empty
- nos  out  WIDTH  entry 1; 0 when size < 2
- size  out  $clog2(DEPTH+1)  valid entries, 0..DEPTH
- empty  out  1  size == 0
- full  out  1  size == DEPTH
- overflow  out  1  sticky, push rejected on full
- underflow  out  1  sticky, op needed more entries than present
- spill_valid  out  1  one-cycle pulse, bottom entry ejected
- spill_data  out  WIDTH  ejected entry, valid with spill_valid

## Operation
- Op codes: 0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 SWAP, 5 DUP, 6–7 NOP.
- PUSH: entries shift down one, entry0 ← din, size+1.
- POP: entries shift up one, vacated bottom ← 0, size−1.
- REPLACE: entry0 ← din, size unchanged; on empty behaves as PUSH.
- SWAP: exchange entry0/entry1; needs size ≥ 2.
- DUP: PUSH of current entry0; needs size ≥ 1.
- Full-stack PUSH/DUP: SPILL_EN=0 → state unchanged, overflow set. SPILL_EN=1 → push proceeds, entry DEPTH−1 driven on spill_data, spill_valid=1, size stays DEPTH, overflow not set.
- Insufficient entries (POP on empty, SWAP with size<2, DUP on empty): state unchanged, underflow set.
- Faulting ops never modify entries or size.
- Flags: set has priority over clear_flags in the same cycle; otherwise clear_flags zeroes both.
- Entries at index ≥ size always hold 0; tos/nos therefore read 0 when invalid.
- size arithmetic never wraps; saturates by the rules above.

## Timing
- All outputs registered; op effect visible one cycle after the sampling edge.
- Back-to-back ops every cycle, no stalls, no ready signal.
- spill_valid high exactly one cycle, coincident with updated tos; 0 otherwise, spill_data 0 when not valid.
- empty/full derived from registered size, consistent with it every cycle.
- async_reset: all entries, size, flags, spill_valid, spill_data ← 0 immediately; tos=nos=0, empty=1, full=0. Op in flight at reset is discarded; first op honoured on first edge after deassertion.

## Structure
- stack_pkg: op_t enum (OP_NOP..OP_DUP), SIZE_W function/localparam helper.
- Sub-module stack_cell: one WIDTH register with hold / load-din / take-prev / take-next / zero select, DEPTH instances via generate; entry0 and entry1 get extra swap path.
- Top holds size counter, op decode, fault/flag logic and spill register.

## Test plan
- WIDTH=16, DEPTH=4: PUSH 0x1111, 0x2222, 0x3333 → tos=0x3333, nos=0x2222, size=3; POP ×3 → tos=0, empty=1, no flags.
- POP on empty → size=0, underflow=1; next cycle clear_flags → underflow=0; clear_flags with POP on empty same cycle → underflow stays 1.
- SPILL_EN=0, push 1..4 then PUSH 5 → size=4, tos=4, overflow=1, spill_valid=0.
- SPILL_EN=1, push 1..4 then PUSH 5 → tos=5, size=4, spill_valid=1 for one cycle with spill_data=1; subsequent POP ×4 yields 5,4,3,2.
- Stack {0xA,0xB}: SWAP → tos=0xB, nos=0xA; DUP → tos=0xB, size=3; REPLACE 0xC → tos=0xC, size=3; SWAP with size 1 → underflow=1, tos unchanged.
- Assert async_reset mid-stream between edges with size=3 → all outputs 0, empty=1 immediately; op codes 6/7 after release leave state unchanged.
